// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; frames go out LSB first with no
// idle gap between queued bytes.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int BIT_CYCLES = CLK_FREQ / BAUD,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    i_data,
    input  logic                          i_valid,
    output logic                          o_ready,
    output logic                          o_tx,
    output logic                          o_busy,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] BAUD_END = BW'(BIT_CYCLES - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    // Handshake: a byte is taken on any rising edge where i_valid && o_ready.
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [1:0]    state;
    logic [BW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tx;

    logic push;
    logic pop;
    logic baud_tick;

    assign o_ready   = (count != FULL);
    assign push      = i_valid && o_ready;
    assign baud_tick = (baud_cnt == BAUD_END);
    // The FIFO is drained only from IDLE or at the very end of a stop bit.
    assign pop       = (count != '0) &&
                       ((state == S_IDLE) || ((state == S_STOP) && baud_tick));

    assign o_tx    = tx;
    assign o_count = count;
    assign o_busy  = (state != S_IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
        end else if ((state == S_IDLE) || baud_tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift <= mem[rd_ptr];
                        state <= S_START;
                        tx    <= 1'b0;
                    end
                end
                S_START: begin
                    if (baud_tick) begin
                        state   <= S_DATA;
                        bit_idx <= '0;
                        tx      <= shift[0];
                    end
                end
                S_DATA: begin
                    if (baud_tick) begin
                        shift <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= S_STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shift[1];
                        end
                    end
                end
                S_STOP: begin
                    if (baud_tick) begin
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= S_START;
                            tx    <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
